// File: rtl/add_seq_ctrl.sv
// Nibble-serial adder: one shared 4-bit slice, registered carry between nibbles.
// Define ADD_SEQ_SUB_EN to add the sub port (A-B via inverted B and carry-in of 1).

module full_add (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

module add_seq_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef ADD_SEQ_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH:0]   sum
);
    localparam int NIB = WIDTH / 4;
    localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, state_nx;

    logic [WIDTH-1:0] a_q, b_q, b_eff, acc, acc_nx, a_sh, b_sh;
    logic             carry, cin0, last, accept;
    logic [IW-1:0]    idx;
    logic [3:0]       sa, sb, ss;
    logic [4:0]       c;

`ifdef ADD_SEQ_SUB_EN
    logic sub_q;
    assign b_eff = sub_q ? ~b_q : b_q;
    assign cin0  = sub;
`else
    assign b_eff = b_q;
    assign cin0  = 1'b0;
`endif

    assign accept = (state == IDLE || state == DONE) && start;
    assign last   = (idx == IW'(NIB - 1));

    // Select the active nibble by shifting rather than a variable part-select.
    assign a_sh = a_q >> {idx, 2'b00};
    assign b_sh = b_eff >> {idx, 2'b00};
    assign sa   = a_sh[3:0];
    assign sb   = b_sh[3:0];
    assign c[0] = carry;

    for (genvar g = 0; g < 4; g++) begin : g_slice
        full_add u_fa (
            .a  (sa[g]),
            .b  (sb[g]),
            .ci (c[g]),
            .s  (ss[g]),
            .co (c[g+1])
        );
    end

    always_comb begin
        acc_nx = acc;
        acc_nx[{idx, 2'b00} +: 4] = ss;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        done     = 1'b0;
        case (state)
            IDLE: if (start) state_nx = RUN;
            RUN: begin
                busy = 1'b1;
                if (last) state_nx = DONE;
            end
            DONE: begin
                done     = 1'b1;
                state_nx = start ? RUN : IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q   <= '0;
            b_q   <= '0;
            acc   <= '0;
            carry <= 1'b0;
            idx   <= '0;
            sum   <= '0;
`ifdef ADD_SEQ_SUB_EN
            sub_q <= 1'b0;
`endif
        end else if (accept) begin
            a_q   <= a;
            b_q   <= b;
            idx   <= '0;
            carry <= cin0;
`ifdef ADD_SEQ_SUB_EN
            sub_q <= sub;
`endif
        end else if (state == RUN) begin
            acc   <= acc_nx;
            carry <= c[4];
            idx   <= idx + 1'b1;
            // Top nibble comes straight from the slice, not from acc.
            if (last) sum <= {c[4], acc_nx};
        end
    end
endmodule

// File: tb/tb_add_seq_ctrl.sv
// Directed bench for add_seq_ctrl (WIDTH=16) with an expected-sum scoreboard.

module tb_add_seq_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] a, b;
    logic        busy, done;
    logic [16:0] sum;
`ifdef ADD_SEQ_SUB_EN
    logic        sub;
`endif

    int vectors = 0;
    int miscompares = 0;
    int done_cnt = 0;
    logic [16:0] exp_q[$];
    logic [16:0] last_exp;

    always #5 clk = ~clk;

    add_seq_ctrl #(.WIDTH(16)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
`ifdef ADD_SEQ_SUB_EN
        .sub   (sub),
`endif
        .busy  (busy),
        .done  (done),
        .sum   (sum)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && done === 1'b1) begin
            done_cnt++;
            if (exp_q.size() == 0) chk("spurious_done", 32'd1, 32'd0);
            else                   chk("sum", {15'd0, sum}, {15'd0, exp_q.pop_front()});
        end
    end

    task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_);
        int nb, nd;
        @(negedge clk);
        a = ta; b = tb_; start = 1'b1;
`ifdef ADD_SEQ_SUB_EN
        sub = 1'b0;
`endif
        last_exp = {1'b0, ta} + {1'b0, tb_};
        exp_q.push_back(last_exp);
        @(posedge clk); #1;
        start = 1'b0;
        a = 16'($urandom); b = 16'($urandom);
        nb = 0; nd = 0;
        repeat (8) begin
            @(negedge clk);
            if (busy === 1'b1) nb++;
            if (done === 1'b1) nd++;
        end
        chk("busy_cycles", nb, 4);
        chk("done_count", nd, 1);
        chk("sum_hold", {15'd0, sum}, {15'd0, last_exp});
    endtask

`ifdef ADD_SEQ_SUB_EN
    task automatic run_sub(input logic [15:0] ta, input logic [15:0] tb_);
        @(negedge clk);
        a = ta; b = tb_; sub = 1'b1; start = 1'b1;
        last_exp = {1'b0, ta} + {1'b0, ~tb_} + 17'd1;
        exp_q.push_back(last_exp);
        @(posedge clk); #1;
        start = 1'b0; sub = 1'b0;
        repeat (8) @(negedge clk);
        chk("sub_hold", {15'd0, sum}, {15'd0, last_exp});
    endtask
`endif

    initial begin
        int d0;
        rst = 1'b1; start = 1'b1;
        a = 16'($urandom); b = 16'($urandom);
`ifdef ADD_SEQ_SUB_EN
        sub = 1'b0;
`endif
        repeat (2) begin
            @(negedge clk);
            chk("rst_busy", {31'd0, busy}, 32'd0);
            chk("rst_done", {31'd0, done}, 32'd0);
            chk("rst_sum", {15'd0, sum}, 32'd0);
            a = 16'($urandom); b = 16'($urandom);
        end
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        chk("start_in_rst_ignored", {31'd0, busy}, 32'd0);

        run_op(16'h0009, 16'h0007);
        run_op(16'hFFFF, 16'h0001);
        run_op(16'h8000, 16'h8000);

        // start pulsed mid-operation must be dropped, not queued
        @(negedge clk);
        a = 16'h1357; b = 16'h2468; start = 1'b1;
        exp_q.push_back({1'b0, a} + {1'b0, b});
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk); @(negedge clk);
        a = 16'hFFFF; b = 16'hFFFF; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        d0 = done_cnt;
        repeat (10) @(negedge clk);
        chk("start_in_run_dones", done_cnt - d0, 1);

        // start held: one op every 5 cycles
        d0 = done_cnt;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (k > 0) chk("held_done", {31'd0, done}, 32'd1);
            a = 16'($urandom); b = 16'($urandom); start = 1'b1;
            exp_q.push_back({1'b0, a} + {1'b0, b});
            repeat (5) @(posedge clk);
        end
        @(negedge clk);
        chk("held_done", {31'd0, done}, 32'd1);
        start = 1'b0;
        @(negedge clk);
        chk("held_done_total", done_cnt - d0, 3);

        // reset at the second RUN cycle aborts with no done
        a = 16'h1234; b = 16'h1111; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        d0 = done_cnt;
        @(negedge clk);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_sum", {15'd0, sum}, 32'd0);
        repeat (6) @(negedge clk);
        chk("abort_no_done", done_cnt - d0, 0);
        run_op(16'h0001, 16'h0001);
        chk("after_abort_sum", {15'd0, sum}, 32'h00002);

`ifdef ADD_SEQ_SUB_EN
        run_sub(16'h0005, 16'h0007);
        chk("sub_neg", {15'd0, sum}, 32'h0FFFE);
        run_sub(16'h0007, 16'h0005);
        chk("sub_pos", {15'd0, sum}, 32'h10002);
`endif

        repeat (2) @(negedge clk);
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
